// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states, write-back select and instruction classes.
package cpu_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    typedef enum logic [3:0] {
        CL_LOAD,
        CL_STORE,
        CL_OP,
        CL_OPIMM,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_LUI,
        CL_AUIPC
    } op_class_t;

    function automatic logic [1:0] wb_sel_for(input op_class_t cls);
        logic [1:0] sel;
        case (cls)
            CL_LOAD:         sel = WB_MEM;
            CL_JAL, CL_JALR: sel = WB_PC4;
            CL_LUI:          sel = WB_IMM;
            default:         sel = WB_ALU;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_op_class.sv
// Opcode classifier: maps the 7-bit opcode field to an instruction class plus a legal flag.
module op_class
    import cpu_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls,
    output logic       legal
);

    always_comb begin
        cls   = CL_OP;
        legal = 1'b1;
        case (opcode)
            OPC_LOAD:   cls = CL_LOAD;
            OPC_STORE:  cls = CL_STORE;
            OPC_OP:     cls = CL_OP;
            OPC_OPIMM:  cls = CL_OPIMM;
            OPC_BRANCH: cls = CL_BRANCH;
            OPC_JAL:    cls = CL_JAL;
            OPC_JALR:   cls = CL_JALR;
            OPC_LUI:    cls = CL_LUI;
            OPC_AUIPC:  cls = CL_AUIPC;
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP) with combinational strobes.
// Define MULTICYCLE_CTRL_PERF_EN to build the 32-bit retired-instruction counter.
module multicycle_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] retired_cnt
);

    state_t    state_q, state_d;
    op_class_t class_q, class_d;
    logic      taken_q, taken_d;
    logic      illegal_q, illegal_d;
    op_class_t dec_class;
    logic      dec_legal;

    op_class u_op_class (
        .opcode (opcode),
        .cls    (dec_class),
        .legal  (dec_legal)
    );

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE:   if (run) state_d = ST_FETCH;
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                class_d = dec_class;
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end
            end
            ST_EXEC: begin
                taken_d = branch_taken;
                state_d = (class_q == CL_LOAD || class_q == CL_STORE) ? ST_MEM : ST_WB;
            end
            ST_MEM:    if (mem_ready) state_d = ST_WB;
            ST_WB:     state_d = run ? ST_FETCH : ST_IDLE;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            class_q   <= CL_OP;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes decode straight from the state so an async reset drops mem_req immediately.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = WB_ALU;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (class_q == CL_STORE);
            end
            ST_WB: begin
                pc_we  = 1'b1;
                pc_src = (class_q == CL_JAL) || (class_q == CL_JALR) ||
                         (class_q == CL_BRANCH && taken_q);
                reg_we = (class_q != CL_STORE) && (class_q != CL_BRANCH);
                wb_sel = wb_sel_for(class_q);
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] retired_q, retired_d;

    always_comb begin
        retired_d = (state_q == ST_WB) ? retired_q + 32'd1 : retired_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 32'd0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_cnt = retired_q;
`else
    assign retired_cnt = 32'd0;
`endif

endmodule
